// File: rtl/emergency_input_conditioner.sv
// Synchronises, debounces and arbitrates four siren lines into one-hot ambulance grants, plus a filtered night request.
// Grant latency DEB_CYCLES+3 edges from first raw sample; release 4 edges; night toggle NIGHT_ON/OFF+2 edges.
module emergency_input_conditioner #(
    parameter logic [31:0] DEB_CYCLES  = 32'd500000,
    parameter logic [31:0] HOLD_CYCLES = 32'd10000000,
    parameter logic [31:0] MAX_CYCLES  = 32'd200000000,
    parameter logic [31:0] NIGHT_ON    = 32'd50000000,
    parameter logic [31:0] NIGHT_OFF   = 32'd50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] siren_raw,
    input  logic       dark_raw,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       A4,
    output logic       night_mode,
    output logic [2:0] active_lane,
    output logic [3:0] lane_lockout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        ACTIVE  = 2'd2,
        LOCKOUT = 2'd3
    } lane_state_e;

    logic [3:0]  siren_meta_q;
    logic [3:0]  siren_sync_q;
    logic        dark_meta_q;
    logic        dark_sync_q;

    lane_state_e state_q [4];
    lane_state_e state_d [4];
    logic [31:0] cnt_q   [4];
    logic [31:0] cnt_d   [4];
    logic [31:0] acnt_q  [4];
    logic [31:0] acnt_d  [4];

    logic [3:0]  req;
    logic [2:0]  own_q;
    logic [2:0]  own_d;
    logic        own_keep;

    logic [31:0] ncnt_q;
    logic [31:0] ncnt_d;
    logic        night_q;
    logic        night_d;
    logic [31:0] night_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            siren_meta_q <= 4'b0000;
            siren_sync_q <= 4'b0000;
            dark_meta_q  <= 1'b0;
            dark_sync_q  <= 1'b0;
        end else begin
            siren_meta_q <= siren_raw;
            siren_sync_q <= siren_meta_q;
            dark_meta_q  <= dark_raw;
            dark_sync_q  <= dark_meta_q;
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            acnt_d[n]  = acnt_q[n];
            case (state_q[n])
                IDLE: begin
                    if (siren_sync_q[n]) begin
                        state_d[n] = QUAL;
                        cnt_d[n]   = 32'd1;
                    end
                end
                QUAL: begin
                    if (!siren_sync_q[n]) begin
                        state_d[n] = IDLE;
                    // A single-cycle debounce qualifies straight out of the first QUAL cycle.
                    end else if ((cnt_q[n] == DEB_CYCLES - 32'd1) || (DEB_CYCLES == 32'd1)) begin
                        state_d[n] = ACTIVE;
                        acnt_d[n]  = 32'd0;
                    end else begin
                        cnt_d[n] = cnt_q[n] + 32'd1;
                    end
                end
                ACTIVE: begin
                    if (acnt_q[n] == MAX_CYCLES - 32'd1) begin
                        state_d[n] = LOCKOUT;
                        cnt_d[n]   = 32'd0;
                    end else if (!siren_sync_q[n] && (acnt_q[n] >= HOLD_CYCLES - 32'd1)) begin
                        state_d[n] = IDLE;
                    end else begin
                        acnt_d[n] = acnt_q[n] + 32'd1;
                    end
                end
                LOCKOUT: begin
                    if (siren_sync_q[n]) begin
                        cnt_d[n] = 32'd0;
                    end else if (cnt_q[n] == DEB_CYCLES - 32'd1) begin
                        state_d[n] = IDLE;
                    end else begin
                        cnt_d[n] = cnt_q[n] + 32'd1;
                    end
                end
                default: begin
                    state_d[n] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= IDLE;
                cnt_q[n]   <= 32'd0;
                acnt_q[n]  <= 32'd0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
                acnt_q[n]  <= acnt_d[n];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            req[n]          = (state_q[n] == ACTIVE);
            lane_lockout[n] = (state_q[n] == LOCKOUT);
        end
    end

    // Non-preemptive: the owner is only replaced once its own request has dropped.
    always_comb begin
        own_keep = 1'b0;
        case (own_q)
            3'd1:    own_keep = req[0];
            3'd2:    own_keep = req[1];
            3'd3:    own_keep = req[2];
            3'd4:    own_keep = req[3];
            default: own_keep = 1'b0;
        endcase

        own_d = own_q;
        if (!own_keep) begin
            if (req[0]) begin
                own_d = 3'd1;
            end else if (req[1]) begin
                own_d = 3'd2;
            end else if (req[2]) begin
                own_d = 3'd3;
            end else if (req[3]) begin
                own_d = 3'd4;
            end else begin
                own_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_q <= 3'd0;
        end else begin
            own_q <= own_d;
        end
    end

    assign A1          = (own_q == 3'd1);
    assign A2          = (own_q == 3'd2);
    assign A3          = (own_q == 3'd3);
    assign A4          = (own_q == 3'd4);
    assign active_lane = own_q;

    // The run counter tracks consecutive samples disagreeing with the current night level.
    always_comb begin
        ncnt_d      = ncnt_q;
        night_d     = night_q;
        night_limit = night_q ? NIGHT_OFF : NIGHT_ON;
        if (dark_sync_q != night_q) begin
            if (ncnt_q == night_limit - 32'd1) begin
                night_d = ~night_q;
                ncnt_d  = 32'd0;
            end else begin
                ncnt_d = ncnt_q + 32'd1;
            end
        end else begin
            ncnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ncnt_q  <= 32'd0;
            night_q <= 1'b0;
        end else begin
            ncnt_q  <= ncnt_d;
            night_q <= night_d;
        end
    end

    assign night_mode = night_q;

endmodule

// File: tb/tb_emergency_input_conditioner.sv
// Directed scenarios followed by random siren/dark traffic, checked every cycle against a timestamp-based reference.
module tb_emergency_input_conditioner;

    localparam int DEB   = 4;
    localparam int HOLD  = 10;
    localparam int MAXC  = 50;
    localparam int NON   = 8;
    localparam int NOFF  = 8;

    localparam int P_IDLE = 0;
    localparam int P_QUAL = 1;
    localparam int P_ACT  = 2;
    localparam int P_LOCK = 3;

    logic       clk;
    logic       reset;
    logic [3:0] siren_raw;
    logic       dark_raw;
    logic       A1, A2, A3, A4;
    logic       night_mode;
    logic [2:0] active_lane;
    logic [3:0] lane_lockout;

    int errors;
    int checks;

    int       ph     [4];
    int       pstart [4];
    int       own_m;
    bit       nm_m;
    int       nrun;
    bit [3:0] ms1, ms2;
    bit       md1, md2;
    int       t;

    emergency_input_conditioner #(
        .DEB_CYCLES (32'(DEB)),
        .HOLD_CYCLES(32'(HOLD)),
        .MAX_CYCLES (32'(MAXC)),
        .NIGHT_ON   (32'(NON)),
        .NIGHT_OFF  (32'(NOFF))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .siren_raw   (siren_raw),
        .dark_raw    (dark_raw),
        .A1          (A1),
        .A2          (A2),
        .A3          (A3),
        .A4          (A4),
        .night_mode  (night_mode),
        .active_lane (active_lane),
        .lane_lockout(lane_lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            ph[n]     = P_IDLE;
            pstart[n] = 0;
        end
        own_m = 0;
        nm_m  = 1'b0;
        nrun  = 0;
        ms1   = 4'b0;
        ms2   = 4'b0;
        md1   = 1'b0;
        md2   = 1'b0;
        t     = 0;
    endtask

    // One clock edge of the reference: pstart holds the edge at which the current phase
    // (or, in lockout, the latest high sample) began, so elapsed time is plain subtraction.
    task automatic model_edge(input logic [3:0] sr, input logic dr);
        bit [3:0] rq;
        int       nxt;
        int       el;
        bit       s;
        for (int n = 0; n < 4; n++) rq[n] = (ph[n] == P_ACT);
        if (own_m != 0 && rq[own_m-1]) begin
            nxt = own_m;
        end else begin
            nxt = 0;
            for (int n = 3; n >= 0; n--) if (rq[n]) nxt = n + 1;
        end
        own_m = nxt;

        for (int n = 0; n < 4; n++) begin
            s  = ms2[n];
            el = t - pstart[n];
            case (ph[n])
                P_IDLE: if (s) begin ph[n] = P_QUAL; pstart[n] = t; end
                P_QUAL: begin
                    if (!s) ph[n] = P_IDLE;
                    else if (el == DEB - 1) begin ph[n] = P_ACT; pstart[n] = t; end
                end
                P_ACT: begin
                    if (el == MAXC) begin ph[n] = P_LOCK; pstart[n] = t; end
                    else if (!s && el >= HOLD) ph[n] = P_IDLE;
                end
                default: begin
                    if (s) pstart[n] = t;
                    else if (el == DEB) ph[n] = P_IDLE;
                end
            endcase
        end

        if (md2 != nm_m) begin
            nrun++;
            if (nrun == (nm_m ? NOFF : NON)) begin
                nm_m = ~nm_m;
                nrun = 0;
            end
        end else begin
            nrun = 0;
        end

        ms2 = ms1;
        ms1 = sr;
        md2 = md1;
        md1 = dr;
        t++;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_a;
        logic [3:0] exp_l;
        exp_a = (own_m == 0) ? 4'b0000 : (4'b0001 << (own_m - 1));
        for (int n = 0; n < 4; n++) exp_l[n] = (ph[n] == P_LOCK);
        chk("grants", 32'({A4, A3, A2, A1}), 32'(exp_a));
        chk("active_lane", 32'(active_lane), 32'(own_m));
        chk("lane_lockout", 32'(lane_lockout), 32'(exp_l));
        chk("night_mode", 32'(night_mode), 32'(nm_m));
        chk("grant_onehot", 32'($countones({A4, A3, A2, A1}) <= 1), 32'd1);
    endtask

    task automatic step(input logic [3:0] sr, input logic dr);
        siren_raw = sr;
        dark_raw  = dr;
        @(posedge clk);
        model_edge(sr, dr);
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, 32'({A4, A3, A2, A1, night_mode, active_lane, lane_lockout}), 32'd0);
    endtask

    initial begin
        logic [3:0] cur_s;
        logic       cur_d;
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        siren_raw = 4'b0000;
        dark_raw  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;

        // Debounce: grant on the 7th edge, release 4 edges after drop.
        for (int k = 1; k <= 20; k++) begin
            step(4'b0001, 1'b0);
            if (k == 6) chk("a1_before_rise", 32'(A1), 32'd0);
            if (k == 7) chk("a1_rise", 32'(active_lane), 32'd1);
        end
        for (int k = 1; k <= 20; k++) begin
            step(4'b0000, 1'b0);
            if (k == 3) chk("a1_release_wait", 32'(A1), 32'd1);
            if (k == 4) chk("a1_release", 32'(A1), 32'd0);
        end

        // Short assert: held until hold time expires.
        for (int k = 1; k <= 8; k++) step(4'b0001, 1'b0);
        for (int k = 9; k <= 25; k++) begin
            step(4'b0000, 1'b0);
            if (k == 16) chk("hold_still_high", 32'(A1), 32'd1);
            if (k == 17) chk("hold_expired", 32'(A1), 32'd0);
        end

        // Glitch rejection on lane 3.
        for (int k = 1; k <= 3; k++) step(4'b0100, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step(4'b0000, 1'b0);
            chk("glitch_no_grant", 32'({A3, active_lane, lane_lockout}), 32'd0);
        end

        // Non-preemption and handover.
        for (int k = 1; k <= 12; k++) step(4'b1000, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step(4'b1001, 1'b0);
            chk("no_preempt", 32'(active_lane), 32'd4);
        end
        for (int k = 1; k <= 10; k++) begin
            step(4'b0001, 1'b0);
            if (k == 3) chk("handover_before", 32'({A4, A1}), 32'b10);
            if (k == 4) chk("handover_edge", 32'({A4, A1}), 32'b01);
        end
        for (int k = 1; k <= 20; k++) step(4'b0000, 1'b0);

        // Max-duration lockout, lockout exit and re-grant.
        for (int k = 1; k <= 100; k++) begin
            step(4'b0010, 1'b0);
            if (k == 56) chk("max_still_granted", 32'(A2), 32'd1);
            if (k == 57) chk("max_dropped", 32'(A2), 32'd0);
        end
        chk("lockout_set", 32'(lane_lockout), 32'b0010);
        for (int k = 1; k <= 6; k++) begin
            step(4'b0000, 1'b0);
            if (k == 5) chk("lockout_holding", 32'(lane_lockout), 32'b0010);
            if (k == 6) chk("lockout_cleared", 32'(lane_lockout), 32'b0000);
        end
        for (int k = 1; k <= 10; k++) begin
            step(4'b0010, 1'b0);
            if (k == 6) chk("regrant_wait", 32'(A2), 32'd0);
            if (k == 7) chk("regrant", 32'(A2), 32'd1);
        end
        for (int k = 1; k <= 20; k++) step(4'b0000, 1'b0);

        // Night filter.
        for (int k = 1; k <= 7; k++) step(4'b0000, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(4'b0000, 1'b0);
            chk("night_short_run", 32'(night_mode), 32'd0);
        end
        for (int k = 1; k <= 12; k++) begin
            step(4'b0000, 1'b1);
            if (k == 9)  chk("night_on_wait", 32'(night_mode), 32'd0);
            if (k == 10) chk("night_on", 32'(night_mode), 32'd1);
        end
        for (int k = 1; k <= 12; k++) begin
            step(4'b0000, 1'b0);
            if (k == 9)  chk("night_off_wait", 32'(night_mode), 32'd1);
            if (k == 10) chk("night_off", 32'(night_mode), 32'd0);
        end

        // Reset mid-operation with lane 2 granted, night on, lane 3 locked out.
        for (int k = 1; k <= 60; k++) step(4'b0100, 1'b1);
        for (int k = 1; k <= 10; k++) step(4'b0110, 1'b1);
        chk("pre_reset_state", 32'({A2, night_mode, lane_lockout}), 32'b1_1_0100);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(4'b0010, 1'b0);
            if (k == 6) chk("post_reset_wait", 32'(A2), 32'd0);
            if (k == 7) chk("post_reset_grant", 32'(A2), 32'd1);
        end
        for (int k = 1; k <= 20; k++) step(4'b0000, 1'b0);

        // Random traffic: slowly toggling sirens and dark sensor.
        cur_s = 4'b0000;
        cur_d = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            for (int n = 0; n < 4; n++)
                if ($urandom_range(0, 15) == 0) cur_s[n] = ~cur_s[n];
            if ($urandom_range(0, 11) == 0) cur_d = ~cur_d;
            step(cur_s, cur_d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/emergency_input_conditioner.md
# emergency_input_conditioner

Front-end conditioning stage that sits directly upstream of the traffic controller FSM and drives its `A1..A4` and `night_mode` inputs. It synchronises and debounces four raw siren-detector lines and a raw ambient-dark sensor. It enforces minimum-hold and maximum-duration rules per lane, and grants at most one ambulance lane at a time. A grant is non-preemptive: once issued, it is kept until the owning lane releases it.

## Interface
- `DEB_CYCLES`, 32'd500000 — consecutive stable synchronised samples needed to qualify a siren assert, or to leave lockout; must be ≥1.
- `HOLD_CYCLES`, 32'd10000000 — minimum cycles a lane stays ACTIVE once qualified.
- `MAX_CYCLES`, 32'd200000000 — maximum cycles a lane may stay ACTIVE before forced lockout; must exceed `HOLD_CYCLES`.
- `NIGHT_ON`, 32'd50000000 — consecutive dark samples needed to assert `night_mode`.
- `NIGHT_OFF`, 32'd50000000 — consecutive light samples needed to deassert `night_mode`.
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-high reset.
- `siren_raw` in 4 — asynchronous siren detectors; bit0 = road 1 … bit3 = road 4.
- `dark_raw` in 1 — asynchronous ambient sensor; 1 = dark.
- `A1`, `A2`, `A3`, `A4` out 1 each — registered, one-hot (or all-zero) ambulance grants to the controller.
- `night_mode` out 1 — registered night request.
- `active_lane` out 3 — registered current grant owner; 0 = none, 1..4 = road.
- `lane_lockout` out 4 — registered; bit n = lane n is in LOCKOUT.

## Operation
- **Synchronisers.** Each of `siren_raw[n]` and `dark_raw` passes through a 2-flop synchroniser; `s[n]` and `d` denote the synchroniser outputs.
- **Per-lane FSM.** Each lane has a 2-bit state, a 32-bit counter `cnt` and a 32-bit counter `acnt`.
  - IDLE: if `s=1`, go to QUAL with `cnt=1`.
  - QUAL:
    - `s=0` → IDLE.
    - `s=1` and `cnt==DEB_CYCLES-1` → ACTIVE with `acnt=0`.
    - Otherwise `cnt++`.
  - ACTIVE: `req[n]=1`. Conditions are checked in this order:
    - `acnt==MAX_CYCLES-1` → LOCKOUT with `cnt=0`.
    - Else `s=0` and `acnt>=HOLD_CYCLES-1` → IDLE.
    - Else `acnt++`.
  - LOCKOUT: `req[n]=0` and `lane_lockout[n]=1`.
    - `s=1` → `cnt=0`.
    - `s=0` and `cnt==DEB_CYCLES-1` → IDLE.
    - Otherwise (`s=0`) `cnt++`.
  - `DEB_CYCLES=1` qualifies on the first `s=1` sample (IDLE→QUAL→ACTIVE with no extra wait beyond one QUAL cycle).
- **Grant arbiter.** Owner register `own` (0..4), updated every edge:
  - If `own!=0` and `req[own]=1`, keep it.
  - Otherwise `own` = lowest-index lane with `req=1`, or 0 if none.
  - Higher-priority requests never preempt a current owner.
  - Outputs: `A(n)=(own==n)`, `active_lane=own`.
- **Night filter.** A 32-bit run counter `ncnt`.
  - When `night_mode=0`: `d=1` increments `ncnt`; `d=0` clears it. When `ncnt==NIGHT_ON-1` and `d=1`, set `night_mode=1` and clear `ncnt`.
  - When `night_mode=1`: the same rule applies with `d=0`, `NIGHT_OFF`, clearing `night_mode`.
- **Arithmetic.** All counters are 32-bit unsigned. Equality compares only; no wrap is reachable because every counter is cleared on exit from its state.

## Timing
- **Reset values.** Synchroniser flops 0, all lane states IDLE, all counters 0, `own=0`. All outputs are 0: `A1..A4`, `night_mode`, `active_lane`, `lane_lockout`.
- **Reset mid-operation.** Reset clears everything immediately (asynchronously), including a lane in ACTIVE or LOCKOUT.
- **Assert latency.** With other lanes idle, `A(n)` rises `DEB_CYCLES+3` edges after the first edge that samples `siren_raw[n]=1`: 2 synchroniser edges, `DEB_CYCLES` qualification edges, 1 grant edge.
- **Release latency.** `A(n)` falls 4 edges after the first edge sampling `siren_raw[n]=0`, provided the hold time is already met. Otherwise it falls at hold expiry plus 1 edge.
- **Glitch rejection.** A high pulse shorter than `DEB_CYCLES` synchronised samples never produces a grant.
- **Simultaneous qualification.** The lowest index wins; the other lane waits with `req=1`.
- **Handover.** On the edge where the owner's `req` drops, `A(old)` falls and `A(new)` rises together. There is no all-zero gap and never two grants asserted at once.
- **Owner lockout.** Treated as a release on that edge.
- **Lockout exit.** A lane in LOCKOUT returns to IDLE only after its siren stays low for `DEB_CYCLES` samples. It re-enters QUAL only on a fresh assert.
- **Night latency.** `night_mode` toggles `NIGHT_ON+2` (or `NIGHT_OFF+2`) edges after the sensor level change is first sampled.

## Test plan
All scenarios use `DEB=4`, `HOLD=10`, `MAX=50`, `NIGHT_ON=NIGHT_OFF=8`.
- **Debounce and hold.** Reset; hold `siren_raw=4'b0001` for 20 cycles → `A1` rises exactly 7 edges after the first sample and `active_lane=1`. Drop to 0 → `A1` stays high until `acnt` has reached 9, then falls.
- **Glitch rejection.** A 3-cycle pulse on `siren_raw[2]` → `A3`, `active_lane` and `lane_lockout` all stay 0 throughout.
- **Non-preemption and handover.** Lane 4 granted, then lane 1 asserted → `A4` holds. On lane 4 release (after hold), `A4` falls and `A1` rises on the same edge; at no cycle are two `A` outputs high.
- **Max-duration lockout.** Hold `siren_raw[1]` high for 100 cycles → `A2` drops 50 ACTIVE cycles after grant and `lane_lockout=4'b0010` stays set. Release for 4 samples → lockout clears; reassert → re-granted after 7 edges.
- **Night filter.** `dark_raw` high for 7 cycles then low → `night_mode` stays 0. High for 8+ cycles → `night_mode=1` at edge 10. Low 8+ cycles → returns to 0.
- **Reset mid-operation.** Assert `reset` while `A2=1`, `night_mode=1` and lane 3 in LOCKOUT → all outputs 0 immediately. After deassert, the full latency of 7 edges applies again.
